instruction_fetch_unit: RTL and testbench

//  Fetch stage upstream of decode/ImmGen. Holds the fetch PC and issues word reads to instruction memory.

---
 rtl/instruction_fetch_unit_pkg.sv | 7 +
 rtl/instruction_fetch_unit_fetch_fifo.sv | 49 ++++
 rtl/instruction_fetch_unit.sv | 104 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage constants used by the fetch unit and its queues.
package instruction_fetch_unit_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO with wrap-bit pointers, combinational head read and a flush.
module fetch_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues word reads, tags responses with their request PC, queues them for decode.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int              XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [XLEN-1:0]    instr_pc
);

    localparam int          CW      = $clog2(FIFO_DEPTH + 1);
    localparam int          DW      = XLEN + INSTR_W;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0] fetch_pc_reg;
    logic [CW-1:0]   drop_cnt_reg;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   count;
    logic [CW:0]     credit_sum;
    logic [XLEN-1:0] tag_pc;
    logic [DW-1:0]   q_head;
    logic            tag_full;
    logic            tag_empty;
    logic            q_full;
    logic            q_empty;
    logic            req_fire;
    logic            pop;
    logic            rsp_live;
    logic            rsp_keep;

    // The tag queue depth equals the number of outstanding requests.
    assign credit_sum     = {1'b0, count} + {1'b0, inflight};
    assign imem_req_valid = (credit_sum < DEPTH_C) & ~q_full & ~tag_full;
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign pop            = instr_valid & instr_ready;
    assign rsp_live       = imem_rsp_valid & ~tag_empty;
    assign rsp_keep       = rsp_live & (drop_cnt_reg == '0) & ~redirect_valid;

    assign instr_valid = ~q_empty;
    assign instruction = q_head[INSTR_W-1:0];
    assign instr_pc    = q_head[DW-1:INSTR_W];

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_fire),
        .pop   (rsp_live),
        .flush (1'b0),
        .din   (fetch_pc_reg),
        .dout  (tag_pc),
        .full  (tag_full),
        .empty (tag_empty),
        .count (inflight)
    );

    fetch_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_instr_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rsp_keep),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({tag_pc, imem_rsp_data}),
        .dout  (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_reg <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc_reg <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (req_fire) begin
            fetch_pc_reg <= fetch_pc_reg + XLEN'(PC_STEP);
        end
    end

    // Every request still outstanding after a redirect, including one firing now, is stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_reg <= '0;
        end else if (redirect_valid) begin
            drop_cnt_reg <= inflight + CW'(req_fire) - CW'(rsp_live);
        end else if (rsp_live && drop_cnt_reg != '0) begin
            drop_cnt_reg <= drop_cnt_reg - CW'(1);
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for the fetch unit with a simple fixed-latency instruction memory model.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [63:0] instr_pc;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 1;
    int fires = 0;
    logic [63:0] mq_addr [$];
    int          mq_due  [$];

    always #5 clk = ~clk;

    instruction_fetch_unit #(.XLEN(64), .RESET_PC(64'h0), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc)
    );

    function automatic logic [31:0] ins(input logic [63:0] a);
        return a[31:0] + 32'h13;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // One clock: record a firing request, then present the oldest due response.
    task automatic tick();
        logic        fire;
        logic [63:0] a;
        fire = imem_req_valid & imem_req_ready & ~reset;
        a    = imem_req_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (fire) begin
            fires++;
            mq_addr.push_back(a);
            mq_due.push_back(cyc - 1 + lat);
        end
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ins(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        tick();
        tick();
        mq_addr.delete();
        mq_due.delete();
        imem_rsp_valid = 1'b0;
        lat            = 1;
        reset          = 1'b0;
    endtask

    initial begin
        int          n;
        logic [63:0] exp_pc;

        // 1: streaming fetch with 1-cycle memory
        do_reset();
        chk("rst_ivalid", 64'(instr_valid), 64'd0);
        chk("rst_reqvalid", 64'(imem_req_valid), 64'd1);
        chk("rst_addr", imem_req_addr, 64'h0);
        chk("rst_drop", 64'(dut.drop_cnt_reg), 64'd0);
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        tick();
        chk("t1_ivalid0", 64'(instr_valid), 64'd0);
        chk("t1_addr4", imem_req_addr, 64'h4);
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("t1_ivalid", 64'(instr_valid), 64'd1);
            chk("t1_pc", instr_pc, 64'(4 * i));
            chk("t1_instr", 64'(instruction), 64'(ins(64'(4 * i))));
            tick();
        end

        // 2: decode stalled, credit limits the number of requests
        do_reset();
        fires          = 0;
        imem_req_ready = 1'b1;
        repeat (10) tick();
        chk("t2_fires", 64'(fires), 64'd4);
        chk("t2_reqvalid0", 64'(imem_req_valid), 64'd0);
        chk("t2_ivalid", 64'(instr_valid), 64'd1);
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_pc", instr_pc, 64'(4 * i));
            chk("t2_instr", 64'(instruction), 64'(ins(64'(4 * i))));
            tick();
        end

        // 3: redirect with two requests in flight on 3-cycle memory
        do_reset();
        lat            = 3;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        tick();
        tick();
        imem_req_ready = 1'b0;
        chk("t3_inflight", 64'(dut.inflight), 64'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        chk("t3_addr", imem_req_addr, 64'h100);
        chk("t3_ivalid0", 64'(instr_valid), 64'd0);
        chk("t3_drop", 64'(dut.drop_cnt_reg), 64'd2);
        exp_pc = 64'h100;
        n      = 0;
        for (int i = 0; i < 12; i++) begin
            if (instr_valid) begin
                chk("t3_pc", instr_pc, exp_pc);
                chk("t3_instr", 64'(instruction), 64'(ins(exp_pc)));
                exp_pc += 64'h4;
                n++;
            end
            tick();
        end
        chk("t3_delivered", 64'(n >= 4), 64'd1);

        // 4: misaligned redirect coinciding with req_fire and a response
        do_reset();
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h203;
        tick();
        redirect_valid = 1'b0;
        chk("t4_addr", imem_req_addr, 64'h200);
        chk("t4_ivalid0", 64'(instr_valid), 64'd0);
        chk("t4_drop1", 64'(dut.drop_cnt_reg), 64'd1);
        tick();
        chk("t4_ivalid1", 64'(instr_valid), 64'd0);
        chk("t4_drop0", 64'(dut.drop_cnt_reg), 64'd0);
        tick();
        chk("t4_ivalid2", 64'(instr_valid), 64'd1);
        chk("t4_pc", instr_pc, 64'h200);
        chk("t4_instr", 64'(instruction), 64'(ins(64'h200)));

        // 5: fetch PC wraps at the top of the address space
        do_reset();
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        chk("t5_addr_f8", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        imem_req_ready = 1'b1;
        tick();
        chk("t5_addr_fc", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("t5_addr_0", imem_req_addr, 64'h0);
        chk("t5_addr_x", 64'($isunknown(imem_req_addr)), 64'd0);
        chk("t5_pc_f8", instr_pc, 64'hFFFF_FFFF_FFFF_FFF8);
        tick();
        chk("t5_pc_fc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("t5_pc_0", instr_pc, 64'h0);
        chk("t5_instr_0", 64'(instruction), 64'h13);

        // 6: reset while requests are outstanding; late responses must be ignored
        do_reset();
        lat            = 3;
        imem_req_ready = 1'b1;
        repeat (4) tick();
        chk("t6_inflight3", 64'(dut.inflight), 64'd3);
        chk("t6_ivalid", 64'(instr_valid), 64'd1);
        chk("t6_pc_pre", instr_pc, 64'h0);
        reset          = 1'b1;
        imem_req_ready = 1'b0;
        tick();
        reset = 1'b0;
        chk("t6_ivalid0", 64'(instr_valid), 64'd0);
        chk("t6_addr", imem_req_addr, 64'h0);
        chk("t6_reqvalid", 64'(imem_req_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_late_ivld", 64'(instr_valid), 64'd0);
        end
        chk("t6_inflight0", 64'(dut.inflight), 64'd0);
        lat            = 1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        exp_pc         = 64'h0;
        n              = 0;
        for (int i = 0; i < 6; i++) begin
            if (instr_valid) begin
                chk("t6_pc", instr_pc, exp_pc);
                chk("t6_instr", 64'(instruction), 64'(ins(exp_pc)));
                exp_pc += 64'h4;
                n++;
            end
            tick();
        end
        chk("t6_delivered", 64'(n >= 3), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
